// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
// Module      : lbp_hist
// Description : 256-bin histogram of LBP codes, streamed out bin by bin.
// Revision    : 1.0
// ============================================================================
module lbp_hist #(
  parameter int CNT_W  = 14,
  parameter int EXPECT = 15876
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  input  logic             hist_ready,
  output logic             hist_valid,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             hist_err,
  output logic             hist_done
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DUMP  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_max    = '1;
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_expect = CNT_W'(EXPECT);
  localparam logic [6:0]       c_last   = 7'd127;

  state_t           r_state;
  logic [CNT_W-1:0] r_bins [256];

  logic [6:0]       w_row;
  logic [6:0]       w_col;
  logic             w_border;
  logic [CNT_W-1:0] w_bin_cur;
  logic [CNT_W-1:0] w_bin_inc;
  logic [CNT_W-1:0] w_pix_inc;
  logic [CNT_W-1:0] w_pix_final;
  logic [CNT_W-1:0] w_first_count;
  logic [7:0]       w_next_bin;
  logic [CNT_W-1:0] w_next_count;

  assign w_row    = lbp_addr[13:7];
  assign w_col    = lbp_addr[6:0];
  assign w_border = (w_row == 7'd0) || (w_row == c_last) ||
                    (w_col == 7'd0) || (w_col == c_last);

  assign w_bin_cur   = r_bins[lbp_data];
  assign w_bin_inc   = (w_bin_cur == c_max) ? w_bin_cur : w_bin_cur + c_one;
  assign w_pix_inc   = (pix_cnt == c_max) ? pix_cnt : pix_cnt + c_one;
  assign w_pix_final = lbp_valid ? w_pix_inc : pix_cnt;

  // A code landing in bin 0 on the finish cycle must already show in the first dump word.
  assign w_first_count = (lbp_valid && (lbp_data == 8'd0)) ? w_bin_inc : r_bins[0];
  assign w_next_bin    = hist_bin + 8'd1;
  assign w_next_count  = r_bins[w_next_bin];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        r_bins[i] <= '0;
      end
      r_state    <= ST_ACCUM;
      pix_cnt    <= '0;
      hist_valid <= 1'b0;
      hist_bin   <= 8'd0;
      hist_count <= '0;
      hist_err   <= 1'b0;
      hist_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (lbp_valid) begin
            r_bins[lbp_data] <= w_bin_inc;
            pix_cnt          <= w_pix_inc;
            if (w_border) begin
              hist_err <= 1'b1;
            end
          end
          if (finish) begin
            r_state    <= ST_DUMP;
            hist_valid <= 1'b1;
            hist_bin   <= 8'd0;
            hist_count <= w_first_count;
            if (w_pix_final != c_expect) begin
              hist_err <= 1'b1;
            end
          end
        end
        ST_DUMP: begin
          if (lbp_valid) begin
            hist_err <= 1'b1;
          end
          if (hist_ready) begin
            if (hist_bin == 8'hFF) begin
              r_state    <= ST_DONE;
              hist_valid <= 1'b0;
              hist_done  <= 1'b1;
            end else begin
              hist_bin   <= w_next_bin;
              hist_count <= w_next_count;
            end
          end
        end
        ST_DONE: begin
          if (lbp_valid) begin
            hist_err <= 1'b1;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lbp_hist.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbp_hist
// Description : Scoreboard bench for lbp_hist (default and 4-bit counter builds).
// Revision    : 1.0
// ============================================================================
module tb_lbp_hist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_valid, a_finish, a_ready;
  logic [13:0] a_addr;
  logic [7:0]  a_data;
  logic        a_hv, a_err, a_done;
  logic [7:0]  a_bin;
  logic [13:0] a_cnt, a_pix;

  logic        b_reset, b_valid, b_finish, b_ready;
  logic [13:0] b_addr;
  logic [7:0]  b_data;
  logic        b_hv, b_err, b_done;
  logic [7:0]  b_bin;
  logic [3:0]  b_cnt, b_pix;

  lbp_hist u_dut_a (
    .clk(clk), .reset(a_reset), .lbp_valid(a_valid), .lbp_addr(a_addr),
    .lbp_data(a_data), .finish(a_finish), .hist_ready(a_ready),
    .hist_valid(a_hv), .hist_bin(a_bin), .hist_count(a_cnt),
    .pix_cnt(a_pix), .hist_err(a_err), .hist_done(a_done)
  );

  lbp_hist #(.CNT_W(4), .EXPECT(15)) u_dut_b (
    .clk(clk), .reset(b_reset), .lbp_valid(b_valid), .lbp_addr(b_addr),
    .lbp_data(b_data), .finish(b_finish), .hist_ready(b_ready),
    .hist_valid(b_hv), .hist_bin(b_bin), .hist_count(b_cnt),
    .pix_cnt(b_pix), .hist_err(b_err), .hist_done(b_done)
  );

  typedef struct {
    int bin;
    int cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   ea[256];
  int   eb[256];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [13:0] c_inner = {7'd5, 7'd9};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors pop one expected word per accepted handshake.
  always @(negedge clk) begin
    if (!a_reset && a_hv && a_ready) begin
      if (qa.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL a_unexpected_word: got bin %0d, expected no output", a_bin);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_bin", 32'(a_bin), 32'(e.bin));
        check("a_count", 32'(a_cnt), 32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (!b_reset && b_hv && b_ready) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL b_unexpected_word: got bin %0d, expected no output", b_bin);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_bin", 32'(b_bin), 32'(e.bin));
        check("b_count", 32'(b_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic push_a();
    for (int i = 0; i < 256; i++) qa.push_back('{i, ea[i]});
  endtask

  task automatic push_b();
    for (int i = 0; i < 256; i++) qb.push_back('{i, eb[i]});
  endtask

  task automatic reset_a();
    a_valid = 0; a_finish = 0; a_ready = 1; a_addr = c_inner; a_data = 0;
    a_reset = 1;
    tick();
    a_reset = 0;
    for (int i = 0; i < 256; i++) ea[i] = 0;
  endtask

  task automatic send_a(input logic [7:0] d);
    a_valid = 1; a_data = d; a_addr = c_inner;
    tick();
    a_valid = 0;
  endtask

  // Edges counted from the finish-sampling edge until hist_done is seen.
  task automatic dump_a(input string name, input int req_edges, input bit stall);
    int  cyc;
    bit  stalled;
    cyc = 0;
    stalled = 0;
    while (!a_done && cyc < 2000) begin
      if (stall && !stalled && a_hv && a_bin == 8'd10) begin
        stalled = 1;
        a_ready = 0;
        for (int k = 0; k < 5; k++) begin
          tick();
          cyc++;
          check("stall_bin", 32'(a_bin), 32'd10);
          check("stall_count", 32'(a_cnt), 32'(ea[10]));
          check("stall_valid", 32'(a_hv), 32'd1);
        end
        a_ready = 1;
      end else begin
        tick();
        cyc++;
      end
    end
    check(name, 32'(cyc), 32'(req_edges));
    check("a_queue_drained", 32'(qa.size()), 32'd0);
  endtask

  initial begin
    b_reset = 1; b_valid = 0; b_finish = 0; b_ready = 1; b_addr = c_inner; b_data = 0;
    a_valid = 0; a_finish = 0; a_ready = 1; a_addr = c_inner; a_data = 0;
    a_reset = 1;
    tick();
    tick();
    check("rst_valid", 32'(a_hv), 32'd0);
    check("rst_bin", 32'(a_bin), 32'd0);
    check("rst_count", 32'(a_cnt), 32'd0);
    check("rst_pix", 32'(a_pix), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    a_reset = 0;
    b_reset = 0;

    // Full frame of code 0x00.
    reset_a();
    for (int i = 0; i < 15876; i++) send_a(8'h00);
    ea[0] = 15876;
    push_a();
    a_finish = 1;
    tick();
    a_finish = 0;
    check("t1_first_valid", 32'(a_hv), 32'd1);
    dump_a("t1_done_latency", 256, 0);
    check("t1_pix", 32'(a_pix), 32'd15876);
    check("t1_err", 32'(a_err), 32'd0);
    check("t1_valid_low", 32'(a_hv), 32'd0);
    send_a(8'h22);
    check("t1_late_err", 32'(a_err), 32'd1);
    check("t1_late_pix", 32'(a_pix), 32'd15876);
    check("t1_done_held", 32'(a_done), 32'd1);

    // Short frame with a stall at bin 10.
    reset_a();
    check("t2_err_cleared", 32'(a_err), 32'd0);
    check("t2_done_cleared", 32'(a_done), 32'd0);
    send_a(8'h05);
    send_a(8'h05);
    send_a(8'hFF);
    ea[5] = 2;
    ea[255] = 1;
    push_a();
    a_finish = 1;
    tick();
    a_finish = 0;
    check("t2_err_count", 32'(a_err), 32'd1);
    dump_a("t2_done_latency", 261, 1);
    check("t2_pix", 32'(a_pix), 32'd3);

    // Valid coinciding with finish.
    reset_a();
    ea[8'h80] = 1;
    push_a();
    a_valid = 1; a_data = 8'h80; a_finish = 1;
    tick();
    a_valid = 0; a_finish = 0;
    check("t3_first_valid", 32'(a_hv), 32'd1);
    check("t3_first_bin", 32'(a_bin), 32'd0);
    dump_a("t3_done_latency", 256, 0);
    check("t3_pix", 32'(a_pix), 32'd1);
    check("t3_err", 32'(a_err), 32'd1);

    // Abort mid-frame, then a clean frame of rotating codes.
    reset_a();
    for (int i = 0; i < 100; i++) send_a(8'h33);
    check("t4_pre_pix", 32'(a_pix), 32'd100);
    reset_a();
    check("t4_rst_pix", 32'(a_pix), 32'd0);
    for (int i = 0; i < 15876; i++) send_a(8'(i));
    for (int i = 0; i < 256; i++) ea[i] = (i < 4) ? 63 : 62;
    push_a();
    a_finish = 1;
    tick();
    a_finish = 0;
    dump_a("t4_done_latency", 256, 0);
    check("t4_pix", 32'(a_pix), 32'd15876);
    check("t4_err", 32'(a_err), 32'd0);

    // 4-bit counters: saturation and border error.
    b_reset = 1;
    tick();
    b_reset = 0;
    for (int i = 0; i < 256; i++) eb[i] = 0;
    for (int i = 0; i < 20; i++) begin
      b_valid = 1; b_data = 8'h01; b_addr = c_inner;
      tick();
    end
    b_valid = 0;
    check("t5_pix_sat", 32'(b_pix), 32'd15);
    check("t5_err_clean", 32'(b_err), 32'd0);
    b_valid = 1; b_data = 8'h01; b_addr = 14'd0;
    tick();
    b_valid = 0; b_addr = c_inner;
    check("t5_border_err", 32'(b_err), 32'd1);
    check("t5_pix_held", 32'(b_pix), 32'd15);
    eb[1] = 15;
    push_b();
    b_finish = 1;
    tick();
    b_finish = 0;
    begin
      int cyc;
      cyc = 0;
      while (!b_done && cyc < 2000) begin
        tick();
        cyc++;
      end
      check("t5_done_latency", 32'(cyc), 32'd256);
    end
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
